// File: rtl/pc_fetch_unit.sv
// PC / instruction fetch unit for the multi-cycle MIPS core.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [1:0]  jump,
  input  logic [1:0]  branch,
  input  logic        zero,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] link_pc,
  output logic        jr_misalign
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ISSUE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        jr_mis_q, jr_mis_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] next_pc;
  logic        br_taken;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Jump codes take priority over branch codes; branch code 01 behaves as none.
  always_comb begin
    br_taken = 1'b0;
    next_pc  = pc_plus4;
    unique case (branch)
      2'b10:   br_taken = zero;
      2'b11:   br_taken = ~zero;
      default: br_taken = 1'b0;
    endcase
    unique case (jump)
      2'b01,
      2'b11:   next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      2'b10:   next_pc = {rs_data[31:2], 2'b00};
      default: next_pc = br_taken ? (pc_plus4 + br_off) : pc_plus4;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    jr_mis_d = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          pc_d     = next_pc;
          jr_mis_d = (jump == 2'b10) && (rs_data[1:0] != 2'b00);
          state_d  = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      jr_mis_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      jr_mis_q <= jr_mis_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ISSUE);
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign pc          = pc_q;
  assign link_pc     = pc_plus4;
  assign jr_misalign = jr_mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [1:0]  jump = '0;
  logic [1:0]  branch = '0;
  logic        zero = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] pc;
  logic [31:0] link_pc;
  logic        jr_misalign;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  pc_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .imem_valid(imem_valid),
    .instr(instr),
    .opcode(opcode),
    .funct(funct),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .jump(jump),
    .branch(branch),
    .zero(zero),
    .rs_data(rs_data),
    .pc(pc),
    .link_pc(link_pc),
    .jr_misalign(jr_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    int unsigned lat;
    logic [1:0]  jump;
    logic [1:0]  branch;
    logic        zero;
    logic [31:0] rs;
    logic [31:0] nxt;
    logic        mis;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h required %08h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Next-PC rules expressed as plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] ins,
                                             input logic [1:0] j, input logic [1:0] b,
                                             input logic z, input logic [31:0] rs);
    logic [31:0]        p4;
    logic signed [31:0] off;
    p4  = cur_pc + 32'd4;
    off = $signed(ins[15:0]);
    if (j == 2'd1 || j == 2'd3) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (j == 2'd2) return rs & ~32'h3;
    if ((b == 2'd2 && z) || (b == 2'd3 && !z)) return p4 + off * 4;
    return p4;
  endfunction

  task automatic wait_req();
    for (int i = 0; i < 20 && !imem_req; i++) step();
    chk("imem_req_seen", {31'b0, imem_req}, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] rdata, input int unsigned lat);
    wait_req();
    chk("imem_addr", imem_addr, addr);
    chk("valid_during_req", {31'b0, instr_valid}, 32'd0);
    for (int unsigned i = 0; i < lat; i++) begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      step();
      chk("req_held", {31'b0, imem_req}, 32'd1);
      chk("valid_during_wait", {31'b0, instr_valid}, 32'd0);
    end
    imem_valid = 1'b1;
    imem_rdata = rdata;
    step();
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    chk("instr_valid", {31'b0, instr_valid}, 32'd1);
    chk("req_in_issue", {31'b0, imem_req}, 32'd0);
    chk("instr", instr, rdata);
    chk("opcode", {26'b0, opcode}, {26'b0, rdata[31:26]});
    chk("funct", {26'b0, funct}, {26'b0, rdata[5:0]});
    chk("pc", pc, addr);
    chk("link_pc", link_pc, addr + 32'd4);
    chk("jr_misalign_idle", {31'b0, jr_misalign}, 32'd0);
  endtask

  task automatic stall(input int unsigned n, input logic [31:0] instr_e, input logic [31:0] pc_e);
    for (int unsigned i = 0; i < n; i++) begin
      instr_ready = 1'b0;
      jump        = 2'($urandom);
      branch      = 2'($urandom);
      zero        = 1'($urandom);
      rs_data     = $urandom;
      imem_valid  = 1'($urandom);
      imem_rdata  = $urandom;
      step();
      chk("stall_instr", instr, instr_e);
      chk("stall_pc", pc, pc_e);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
    end
    imem_valid = 1'b0;
  endtask

  task automatic retire(input logic [1:0] j, input logic [1:0] b, input logic z,
                        input logic [31:0] rs, input logic mis_e);
    jump        = j;
    branch      = b;
    zero        = z;
    rs_data     = rs;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    jump        = 2'($urandom);
    branch      = 2'($urandom);
    zero        = 1'($urandom);
    rs_data     = $urandom;
    chk("jr_misalign", {31'b0, jr_misalign}, {31'b0, mis_e});
    chk("valid_after_retire", {31'b0, instr_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] pc_m, rd, rs, nxt;
    logic [1:0]  j, b;
    logic        z, mis;

    vecs[0]  = '{32'h0000_3000, 32'h2008_0005, 1, 2'd0, 2'd0, 1'b0, 32'h0,         32'h0000_3004, 1'b0};
    vecs[1]  = '{32'h0000_3004, 32'h0000_0020, 0, 2'd0, 2'd0, 1'b0, 32'h0,         32'h0000_3008, 1'b0};
    vecs[2]  = '{32'h0000_3008, 32'h8C01_0004, 2, 2'd0, 2'd0, 1'b1, 32'h0,         32'h0000_300C, 1'b0};
    vecs[3]  = '{32'h0000_300C, 32'h0000_0000, 0, 2'd0, 2'd0, 1'b0, 32'h0,         32'h0000_3010, 1'b0};
    vecs[4]  = '{32'h0000_3010, 32'h1000_FFFE, 1, 2'd0, 2'd2, 1'b1, 32'h0,         32'h0000_300C, 1'b0};
    vecs[5]  = '{32'h0000_300C, 32'h0000_0000, 0, 2'd0, 2'd0, 1'b0, 32'h0,         32'h0000_3010, 1'b0};
    vecs[6]  = '{32'h0000_3010, 32'h1000_FFFE, 0, 2'd0, 2'd2, 1'b0, 32'h0,         32'h0000_3014, 1'b0};
    vecs[7]  = '{32'h0000_3014, 32'h0800_0C00, 1, 2'd1, 2'd0, 1'b0, 32'h0,         32'h0000_3000, 1'b0};
    vecs[8]  = '{32'h0000_3000, 32'h0C00_0C10, 0, 2'd3, 2'd0, 1'b0, 32'h0,         32'h0000_3040, 1'b0};
    vecs[9]  = '{32'h0000_3040, 32'h0060_0008, 0, 2'd2, 2'd0, 1'b0, 32'h0000_3102, 32'h0000_3100, 1'b1};
    vecs[10] = '{32'h0000_3100, 32'h1400_0004, 0, 2'd0, 2'd3, 1'b0, 32'h0,         32'h0000_3114, 1'b0};
    vecs[11] = '{32'h0000_3114, 32'h1400_0004, 2, 2'd0, 2'd3, 1'b1, 32'h0,         32'h0000_3118, 1'b0};
    vecs[12] = '{32'h0000_3118, 32'h1000_0004, 0, 2'd0, 2'd1, 1'b1, 32'h0,         32'h0000_311C, 1'b0};
    vecs[13] = '{32'h0000_311C, 32'h0060_0008, 0, 2'd2, 2'd0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
    vecs[14] = '{32'hFFFF_FFFC, 32'h0000_0000, 0, 2'd0, 2'd0, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
    vecs[15] = '{32'h0000_0000, 32'h0800_0C00, 1, 2'd1, 2'd2, 1'b1, 32'h0,         32'h0000_3000, 1'b0};

    // Reset state
    reset = 1'b1;
    step();
    step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_jr_misalign", {31'b0, jr_misalign}, 32'd0);
    reset = 1'b0;

    // Directed vector table
    for (int unsigned i = 0; i < 16; i++) begin
      fetch(vecs[i].addr, vecs[i].rdata, vecs[i].lat);
      retire(vecs[i].jump, vecs[i].branch, vecs[i].zero, vecs[i].rs, vecs[i].mis);
    end

    // Long stall in ISSUE with noise on imem_valid and control inputs
    fetch(32'h0000_3000, 32'h2008_0005, 1);
    stall(5, 32'h2008_0005, 32'h0000_3000);
    retire(2'd0, 2'd0, 1'b0, 32'h0, 1'b0);

    // Reset while a fetch is outstanding
    wait_req();
    chk("pre_reset_addr", imem_addr, 32'h0000_3004);
    reset = 1'b1;
    step();
    chk("abort_req", {31'b0, imem_req}, 32'd0);
    chk("abort_valid", {31'b0, instr_valid}, 32'd0);
    chk("abort_pc", pc, 32'h0000_3000);
    chk("abort_instr", instr, 32'h0);
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    reset      = 1'b0;
    step();
    imem_valid = 1'b0;
    chk("late_valid_req", {31'b0, imem_req}, 32'd1);
    chk("late_valid_instr", instr, 32'h0);
    chk("late_valid_valid", {31'b0, instr_valid}, 32'd0);
    fetch(32'h0000_3000, 32'h1234_5678, 0);
    retire(2'd0, 2'd0, 1'b0, 32'h0, 1'b0);

    // Randomized traffic against the reference model
    pc_m = 32'h0000_3004;
    for (int unsigned t = 0; t < 150; t++) begin
      rd = $urandom;
      fetch(pc_m, rd, $urandom_range(0, 2));
      stall($urandom_range(0, 2), rd, pc_m);
      j  = 2'($urandom);
      b  = 2'($urandom);
      z  = 1'($urandom);
      rs = $urandom;
      if ($urandom_range(0, 1) == 0) rs[1:0] = 2'b00;
      mis = (j == 2'd2) && (rs[1:0] != 2'b00);
      nxt = model_next(pc_m, rd, j, b, z, rs);
      retire(j, b, z, rs, mis);
      pc_m = nxt;
    end
    wait_req();
    chk("final_addr", imem_addr, pc_m);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
